// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32_mem_pkg;

    // Responder mode: filling RAM from the boot stream, or serving the running core.
    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Byte offsets inside the 8-byte MMIO window.
    localparam logic [31:0] MMIO_CNT_OFS    = 32'h0000_0000;
    localparam logic [31:0] MMIO_TOHOST_OFS = 32'h0000_0004;

    // Returned on instruction fetches that decode to nothing.
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32_byte_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words for the RAM write port.
// Latency: a word is presented combinationally on the cycle its 4th (or last) byte is accepted.
// Backpressure: ready is high for the whole load phase; bytes past the end of RAM are taken and dropped.
//
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_load_valid/_data/_last            byte stream in; o_load_ready handshake
//   o_wr_en, o_wr_idx, o_wr_data        one-cycle full-word RAM write request
//   o_done                              high once the last byte has been taken (run mode)
//   o_overflow                          pulse when a byte arrives with RAM already full
module rv32_byte_loader
    import rv32_mem_pkg::*;
#(
    parameter int MEM_WORDS   = 4096,
    parameter bit LOAD_ENABLE = 1'b1,
    localparam int IW         = $clog2(MEM_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load_valid,
    input  logic [7:0]    i_load_data,
    input  logic          i_load_last,
    output logic          o_load_ready,
    output logic          o_wr_en,
    output logic [IW-1:0] o_wr_idx,
    output logic [31:0]   o_wr_data,
    output logic          o_done,
    output logic          o_overflow
);

    // Word counter is one bit wider than the index so "RAM full" is representable.
    localparam logic [IW:0] FULL_CNT = (IW+1)'(MEM_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_byte_cnt;
    logic [IW:0] r_word_cnt;
    logic [31:0] r_asm;
    logic        w_accept;
    logic        w_full;
    logic        w_word_done;
    logic [31:0] w_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LOAD_ENABLE ? S_LOAD : S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_load_ready = 1'b0;
        w_accept     = 1'b0;
        if (r_state == S_LOAD) begin
            o_load_ready = 1'b1;
            w_accept     = i_load_valid;
            if (i_load_valid && i_load_last) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    // Current byte merged into the assembly word; lanes not yet filled stay zero
    // because r_asm is cleared after every emitted word.
    always_comb begin
        w_word = r_asm;
        w_word[{r_byte_cnt, 3'b000} +: 8] = i_load_data;
    end

    assign w_full      = (r_word_cnt == FULL_CNT);
    assign w_word_done = w_accept && ((r_byte_cnt == 2'd3) || i_load_last);

    assign o_wr_en    = w_word_done && !w_full;
    assign o_wr_idx   = r_word_cnt[IW-1:0];
    assign o_wr_data  = w_word;
    assign o_done     = (r_state == S_RUN);
    assign o_overflow = w_accept && w_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
            r_asm      <= 32'h0;
        end else if (w_accept) begin
            if (w_word_done) begin
                r_asm      <= 32'h0;
                r_byte_cnt <= 2'd0;
                if (!w_full) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end else begin
                r_asm      <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/rv32_mem_responder.sv
// Unified instruction/data RAM plus MMIO (cycle counter, tohost) and boot loader for the RV32 core.
// Latency: reads are combinational; writes land on the next rising edge (same-cycle read sees old data).
// Backpressure: none toward the core; the core is held in reset while the loader fills RAM.
//
// Ports:
//   clk_i, rst_n_i                      clock, async active-low reset
//   instr_address_i -> instr_o          fetch port (misses return NOP)
//   data_address_i, write_enable_i,
//   write_data_i -> read_data_o         load/store port (byte-lane strobes)
//   load_valid_i/_data_i/_last_i,
//   load_ready_o                        boot byte stream
//   core_rst_n_o                        core reset, released one cycle after loading ends
//   tohost_valid_o, tohost_data_o       sticky tohost flag and last written value
//   error_o                             sticky out-of-range / load overflow flag
module rv32_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter bit          LOAD_ENABLE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] instr_address_i,
    output logic [31:0] instr_o,
    input  logic [31:0] data_address_i,
    input  logic [3:0]  write_enable_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    input  logic        load_valid_i,
    input  logic [7:0]  load_data_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    output logic        core_rst_n_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o,
    output logic        error_o
);

    localparam int          IW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    logic [31:0]   r_mem [MEM_WORDS];
    logic [31:0]   r_cnt;
    logic [31:0]   r_tohost;
    logic          r_tohost_vld;
    logic          r_error;
    logic          r_core_rst_n;

    logic          w_run;
    logic          w_ld_we;
    logic [IW-1:0] w_ld_idx;
    logic [31:0]   w_ld_data;
    logic          w_ld_ovf;

    logic          w_i_ram;
    logic          w_i_mmio;
    logic          w_d_ram;
    logic          w_d_mmio;
    logic          w_set_err;

    logic [3:0]    w_ram_we;
    logic [IW-1:0] w_ram_idx;
    logic [31:0]   w_ram_wdata;

    rv32_byte_loader #(
        .MEM_WORDS   (MEM_WORDS),
        .LOAD_ENABLE (LOAD_ENABLE)
    ) u_loader (
        .i_clk        (clk_i),
        .i_rst_n      (rst_n_i),
        .i_load_valid (load_valid_i),
        .i_load_data  (load_data_i),
        .i_load_last  (load_last_i),
        .o_load_ready (load_ready_o),
        .o_wr_en      (w_ld_we),
        .o_wr_idx     (w_ld_idx),
        .o_wr_data    (w_ld_data),
        .o_done       (w_run),
        .o_overflow   (w_ld_ovf)
    );

    // Address decode; address[1:0] never selects anything.
    assign w_i_ram  = (instr_address_i < RAM_BYTES);
    assign w_i_mmio = (instr_address_i[31:3] == MMIO_BASE[31:3]);
    assign w_d_ram  = (data_address_i < RAM_BYTES);
    assign w_d_mmio = (data_address_i[31:3] == MMIO_BASE[31:3]);

    always_comb begin
        instr_o = NOP;
        if (w_i_ram) begin
            instr_o = r_mem[instr_address_i[IW+1:2]];
        end else if (w_i_mmio) begin
            instr_o = (instr_address_i[2] == MMIO_CNT_OFS[2]) ? r_cnt : r_tohost;
        end
    end

    always_comb begin
        read_data_o = 32'h0;
        if (w_d_ram) begin
            read_data_o = r_mem[data_address_i[IW+1:2]];
        end else if (w_d_mmio) begin
            read_data_o = (data_address_i[2] == MMIO_CNT_OFS[2]) ? r_cnt : r_tohost;
        end
    end

    // Single RAM write port. The loader only writes while loading and the core
    // only while running, so the two sources never compete.
    always_comb begin
        w_ram_we    = 4'b0000;
        w_ram_idx   = w_ld_idx;
        w_ram_wdata = w_ld_data;
        if (w_ld_we) begin
            w_ram_we = 4'b1111;
        end else if (w_run && w_d_ram) begin
            w_ram_we    = write_enable_i;
            w_ram_idx   = data_address_i[IW+1:2];
            w_ram_wdata = write_data_i;
        end
    end

    // RAM contents deliberately survive reset so a reload can overwrite selectively.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < 4; n++) begin
            if (w_ram_we[n]) begin
                r_mem[w_ram_idx][8*n +: 8] <= w_ram_wdata[8*n +: 8];
            end
        end
    end

    // Misses only count once the core is live; before that its address buses carry no intent.
    assign w_set_err = w_ld_ovf ||
                       (w_run && (!(w_i_ram || w_i_mmio) || !(w_d_ram || w_d_mmio)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt        <= 32'h0;
            r_tohost     <= 32'h0;
            r_tohost_vld <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= !LOAD_ENABLE;
        end else begin
            r_core_rst_n <= w_run;
            if (w_run) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_set_err) begin
                r_error <= 1'b1;
            end
            if (w_run && w_d_mmio && (data_address_i[2] == MMIO_TOHOST_OFS[2]) &&
                (write_enable_i != 4'b0000)) begin
                for (int n = 0; n < 4; n++) begin
                    if (write_enable_i[n]) begin
                        r_tohost[8*n +: 8] <= write_data_i[8*n +: 8];
                    end
                end
                r_tohost_vld <= 1'b1;
            end
        end
    end

    assign core_rst_n_o   = r_core_rst_n;
    assign tohost_valid_o = r_tohost_vld;
    assign tohost_data_o  = r_tohost;
    assign error_o        = r_error;

endmodule

// File: tb/tb_rv32_mem_responder.sv
// Self-checking bench for rv32_mem_responder: directed boot/run scenarios plus random core traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32_mem_responder;

    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ia    = 32'h0;
    logic [31:0] da    = 32'h0;
    logic [3:0]  we    = 4'h0;
    logic [31:0] wd    = 32'h0;
    logic        lv    = 1'b0;
    logic [7:0]  ld    = 8'h0;
    logic        ll    = 1'b0;

    logic [31:0] instr_o, read_data_o, tohost_data_o;
    logic        load_ready_o, core_rst_n_o, tohost_valid_o, error_o;

    logic [31:0] z_instr, z_rdata, z_thd;
    logic        z_ready, z_core, z_thv, z_err;

    always #5 clk = ~clk;

    rv32_mem_responder #(.MEM_WORDS(MW), .MMIO_BASE(BASE), .LOAD_ENABLE(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .instr_address_i(ia), .instr_o(instr_o),
        .data_address_i(da), .write_enable_i(we), .write_data_i(wd), .read_data_o(read_data_o),
        .load_valid_i(lv), .load_data_i(ld), .load_last_i(ll), .load_ready_o(load_ready_o),
        .core_rst_n_o(core_rst_n_o), .tohost_valid_o(tohost_valid_o),
        .tohost_data_o(tohost_data_o), .error_o(error_o)
    );

    // No-boot variant: idle core buses, no load stream.
    logic [31:0] zero32 = 32'h0;
    logic [3:0]  zero4  = 4'h0;
    logic [7:0]  zero8  = 8'h0;
    logic        zero1  = 1'b0;

    rv32_mem_responder #(.MEM_WORDS(MW), .MMIO_BASE(BASE), .LOAD_ENABLE(1'b0)) dut_nl (
        .clk_i(clk), .rst_n_i(rst_n),
        .instr_address_i(zero32), .instr_o(z_instr),
        .data_address_i(zero32), .write_enable_i(zero4), .write_data_i(zero32), .read_data_o(z_rdata),
        .load_valid_i(zero1), .load_data_i(zero8), .load_last_i(zero1), .load_ready_o(z_ready),
        .core_rst_n_o(z_core), .tohost_valid_o(z_thv),
        .tohost_data_o(z_thd), .error_o(z_err)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [MW];
    bit   [3:0]  m_kn  [MW];     // which byte lanes of each word hold a known value
    bit          m_run  = 1'b0;
    bit          m_core = 1'b0;
    int          m_byte = 0;
    int          m_words = 0;
    logic [31:0] m_asm = 32'h0;
    logic [31:0] m_cnt = 32'h0;
    logic [31:0] m_th  = 32'h0;
    bit          m_tv  = 1'b0;
    bit          m_err = 1'b0;
    bit          was_run;
    int          widx;

    int n_pass  = 0;
    int n_total = 0;

    function automatic bit in_ram(input logic [31:0] a);
        return a < 32'(MW * 4);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        logic [31:0] b;
        b = BASE;
        return a[31:3] == b[31:3];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input bit fetch);
        if (in_ram(a)) return m_mem[int'(a >> 2)];
        if (in_mmio(a)) return a[2] ? m_th : m_cnt;
        return fetch ? 32'h0000_0013 : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] exp_mask(input logic [31:0] a);
        logic [31:0] mk;
        bit   [3:0]  kn;
        if (!in_ram(a)) return 32'hFFFF_FFFF;
        kn = m_kn[int'(a >> 2)];
        for (int l = 0; l < 4; l++) mk[8*l +: 8] = {8{kn[l]}};
        return mk;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_core = 1'b0; m_byte = 0; m_words = 0; m_asm = 32'h0;
            m_cnt = 32'h0; m_th = 32'h0; m_tv = 1'b0; m_err = 1'b0;
        end else begin
            was_run = m_run;
            if (was_run) begin
                m_cnt = m_cnt + 32'd1;
                if (!(in_ram(ia) || in_mmio(ia)) || !(in_ram(da) || in_mmio(da))) m_err = 1'b1;
                if (we != 4'h0) begin
                    if (in_ram(da)) begin
                        widx = int'(da >> 2);
                        for (int l = 0; l < 4; l++) begin
                            if (we[l]) begin
                                m_mem[widx][8*l +: 8] = wd[8*l +: 8];
                                m_kn[widx][l] = 1'b1;
                            end
                        end
                    end else if (in_mmio(da) && da[2]) begin
                        for (int l = 0; l < 4; l++) if (we[l]) m_th[8*l +: 8] = wd[8*l +: 8];
                        m_tv = 1'b1;
                    end
                end
            end else if (lv) begin
                if (m_words == MW) begin
                    m_err = 1'b1;
                end else begin
                    m_asm[8*m_byte +: 8] = ld;
                    if (m_byte == 3 || ll) begin
                        m_mem[m_words] = m_asm;
                        m_kn[m_words]  = 4'hF;
                        m_words++;
                        m_asm = 32'h0;
                    end
                end
                m_byte = (ll || m_byte == 3) ? 0 : m_byte + 1;
                if (ll) m_run = 1'b1;
            end
            m_core = was_run;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_m(input string nm, input logic [31:0] act, input logic [31:0] exp,
                         input logic [31:0] mk);
        if (mk == 32'h0) return;
        n_total++;
        if ((act & mk) === (exp & mk)) n_pass++;
        else $display("FAIL %s: got %08h, want %08h mask %08h (t=%0t)", nm, act, exp, mk, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk_m("instr", instr_o, exp_rd(ia, 1'b1), exp_mask(ia));
            chk_m("rdata", read_data_o, exp_rd(da, 1'b0), exp_mask(da));
            chk("load_ready", {31'h0, load_ready_o}, {31'h0, !m_run});
            chk("core_rst_n", {31'h0, core_rst_n_o}, {31'h0, m_core});
            chk("tohost_valid", {31'h0, tohost_valid_o}, {31'h0, m_tv});
            chk("tohost_data", tohost_data_o, m_th);
            chk("error", {31'h0, error_o}, {31'h0, m_err});
            chk("nl_core_rst_n", {31'h0, z_core}, 32'h1);
            chk("nl_load_ready", {31'h0, z_ready}, 32'h0);
            chk("nl_error", {31'h0, z_err}, 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        lv = 1'b1; ld = d; ll = last;
        tick();
        lv = 1'b0; ll = 1'b0;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [7:0]  boot [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] v1, v2;

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_load_ready", {31'h0, load_ready_o}, 32'h1);
        chk("rst_core_rst_n", {31'h0, core_rst_n_o}, 32'h0);
        chk("rst_tohost_valid", {31'h0, tohost_valid_o}, 32'h0);
        chk("rst_tohost_data", tohost_data_o, 32'h0);
        chk("rst_error", {31'h0, error_o}, 32'h0);
        chk("nl_rst_core", {31'h0, z_core}, 32'h1);
        chk("nl_rst_ready", {31'h0, z_ready}, 32'h0);

        // Boot two words, last flag on the 8th byte.
        for (int i = 0; i < 8; i++) send(boot[i], (i == 7));
        #1;
        chk("boot_core_still_low", {31'h0, core_rst_n_o}, 32'h0);
        chk("boot_ready_low", {31'h0, load_ready_o}, 32'h0);
        tick(); #1;
        chk("boot_core_released", {31'h0, core_rst_n_o}, 32'h1);
        da = 32'h0; ia = 32'h4; #1;
        chk("boot_ram0", read_data_o, 32'h0010_0513);
        chk("boot_ram1", instr_o, 32'hDEAD_BEEF);

        // Partial store into lane 1; same-cycle read sees the old word.
        tick();
        da = 32'h8; we = 4'hF; wd = 32'hDEAD_BEEF;
        tick();
        we = 4'b0010; wd = 32'h0000_AA00; #1;
        chk("store_same_cycle_old", read_data_o, 32'hDEAD_BEEF);
        tick();
        we = 4'h0; #1;
        chk("store_lane1", read_data_o, 32'hDEAD_AAEF);

        // tohost and cycle counter.
        da = 32'h8000_0004; we = 4'hF; wd = 32'h1;
        tick();
        we = 4'h0; #1;
        chk("tohost_valid_set", {31'h0, tohost_valid_o}, 32'h1);
        chk("tohost_value", tohost_data_o, 32'h1);
        da = 32'h8000_0000; #1;
        v1 = read_data_o;
        tick(); #1;
        v2 = read_data_o;
        chk("counter_step", v2 - v1, 32'h1);

        // Out-of-range fetch and store.
        da = 32'h0; ia = 32'(MW * 4); #1;
        chk("fetch_miss_nop", instr_o, 32'h0000_0013);
        chk("err_before_miss", {31'h0, error_o}, 32'h0);
        tick(); #1;
        chk("err_after_miss", {31'h0, error_o}, 32'h1);
        ia = 32'h0; da = 32'(MW * 4); we = 4'hF; wd = 32'h1234_5678;
        tick();
        we = 4'h0; #1;
        chk("miss_read_zero", read_data_o, 32'h0);
        da = 32'h0; #1;
        chk("miss_store_no_alias", read_data_o, 32'h0010_0513);

        // Random core traffic, checked every cycle by the compare process.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0)
                da = BASE | 32'($urandom_range(0, 1) << 2) | 32'($urandom_range(0, 3));
            else
                da = 32'($urandom_range(0, MW - 1) << 2) | 32'($urandom_range(0, 3));
            ia = 32'($urandom_range(0, MW - 1) << 2);
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            wd = $urandom;
            tick();
        end
        we = 4'h0; da = 32'h0; ia = 32'h0;

        // Reset mid-load: partial word must be discarded.
        pulse_reset(); #1;
        chk("reload_ready", {31'h0, load_ready_o}, 32'h1);
        chk("reload_error_clr", {31'h0, error_o}, 32'h0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        pulse_reset();
        for (int i = 1; i <= 5; i++) send(8'(i), (i == 5));
        tick();
        da = 32'h0; #1;
        chk("reload_ram0", read_data_o, 32'h0403_0201);
        da = 32'h4; #1;
        chk("reload_ram1", read_data_o, 32'h0000_0005);
        chk("reload_run", {31'h0, load_ready_o}, 32'h0);
        chk("reload_core", {31'h0, core_rst_n_o}, 32'h1);

        // Overflow: fill all of RAM, then a few extra bytes.
        da = 32'h0;
        pulse_reset();
        for (int i = 0; i < MW * 4 + 6; i++) begin
            send(8'($urandom), (i == MW * 4 + 5));
            if (i == MW * 4 - 1) begin
                #1 chk("ovf_not_yet", {31'h0, error_o}, 32'h0);
            end
        end
        #1;
        chk("ovf_error", {31'h0, error_o}, 32'h1);
        for (int k = 0; k < 50; k++) begin
            da = 32'($urandom_range(0, MW - 1) << 2);
            ia = 32'($urandom_range(0, MW - 1) << 2);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
